// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port synchronous video RAM between the VGA
// scan-out fetch path and a CPU read/write port. VGA has priority; a bounded
// defer counter lets a starved CPU request win over a pending VGA fetch.

module vram_arbiter #(
    parameter int unsigned VRAM_WORDS      = 768,
    parameter int unsigned MEM_ADDR_OFFSET = 0,
    parameter int unsigned MAX_DEFER       = 8
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [15:0] vga_addr,
    output logic [15:0] vga_data,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ready,
    output logic [15:0] cpu_rdata,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    input  logic [15:0] mem_rdata
);

    localparam int unsigned      DeferW   = $clog2(MAX_DEFER + 1);
    localparam logic [DeferW-1:0] DeferMax = DeferW'(MAX_DEFER);
    localparam logic [16:0]      RangeLo  = 17'(MEM_ADDR_OFFSET);
    localparam logic [16:0]      RangeHi  = 17'(MEM_ADDR_OFFSET + VRAM_WORDS);

    typedef enum logic [2:0] {
        StIdle,
        StVgaRd,
        StVgaCap,
        StCpuRd,
        StCpuCap,
        StCpuWr
    } state_e;

    state_e              state_q, state_d;
    logic [15:0]         vga_data_q, vga_data_d;
    logic [15:0]         cpu_rdata_q, cpu_rdata_d;
    logic                cpu_ready_q, cpu_ready_d;
    logic [15:0]         mem_addr_q, mem_addr_d;
    logic [15:0]         mem_wdata_q, mem_wdata_d;
    logic                mem_we_q, mem_we_d;
    logic [15:0]         fetched_addr_q, fetched_addr_d;
    logic                fetched_valid_q, fetched_valid_d;
    logic [DeferW-1:0]   defer_q, defer_d;

    logic vga_pend;
    logic cpu_ok;
    logic in_range;
    logic defer_full;
    logic cpu_grant;

    // The VGA word is stale whenever the scan-out address moved off the last fetch.
    assign vga_pend   = !fetched_valid_q || (vga_addr != fetched_addr_q);
    // Blocks re-serving a request in its own completion cycle.
    assign cpu_ok     = cpu_req && !cpu_ready_q;
    assign in_range   = ({1'b0, cpu_addr} >= RangeLo) && ({1'b0, cpu_addr} < RangeHi);
    assign defer_full = (defer_q == DeferMax);

    // Next-state, datapath latches and defer counter update.
    always_comb begin
        state_d         = state_q;
        vga_data_d      = vga_data_q;
        cpu_rdata_d     = cpu_rdata_q;
        cpu_ready_d     = 1'b0;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        mem_we_d        = 1'b0;
        fetched_addr_d  = fetched_addr_q;
        fetched_valid_d = fetched_valid_q;
        cpu_grant       = 1'b0;

        case (state_q)
            StIdle: begin
                if (vga_pend && !(cpu_ok && defer_full)) begin
                    mem_addr_d     = vga_addr;
                    fetched_addr_d = vga_addr;
                    state_d        = StVgaRd;
                end else if (cpu_ok) begin
                    cpu_grant  = 1'b1;
                    mem_addr_d = cpu_addr;
                    if (cpu_we) begin
                        // Out-of-range writes are dropped but still acknowledged.
                        if (in_range) begin
                            mem_wdata_d = cpu_wdata;
                            mem_we_d    = 1'b1;
                        end
                        state_d = StCpuWr;
                    end else begin
                        state_d = StCpuRd;
                    end
                end
            end
            StVgaRd: state_d = StVgaCap;
            StVgaCap: begin
                vga_data_d      = mem_rdata;
                fetched_valid_d = 1'b1;
                state_d         = StIdle;
            end
            StCpuRd: state_d = StCpuCap;
            StCpuCap: begin
                cpu_rdata_d = in_range ? mem_rdata : 16'h0000;
                cpu_ready_d = 1'b1;
                state_d     = StIdle;
            end
            StCpuWr: begin
                cpu_ready_d = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (cpu_grant || !cpu_req) begin
            defer_d = '0;
        end else if (cpu_ok && !defer_full) begin
            defer_d = defer_q + DeferW'(1);
        end else begin
            defer_d = defer_q;
        end
    end

    // State register; clear returns everything to reset values immediately.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q         <= StIdle;
            vga_data_q      <= '0;
            cpu_rdata_q     <= '0;
            cpu_ready_q     <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            mem_we_q        <= 1'b0;
            fetched_addr_q  <= '0;
            fetched_valid_q <= 1'b0;
            defer_q         <= '0;
        end else begin
            state_q         <= state_d;
            vga_data_q      <= vga_data_d;
            cpu_rdata_q     <= cpu_rdata_d;
            cpu_ready_q     <= cpu_ready_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            mem_we_q        <= mem_we_d;
            fetched_addr_q  <= fetched_addr_d;
            fetched_valid_q <= fetched_valid_d;
            defer_q         <= defer_d;
        end
    end

    assign vga_data  = vga_data_q;
    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ready = cpu_ready_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed and randomized checks of vram_arbiter against a
// shadow-memory scoreboard and latency rules computed in the bench.

module tb_vram_arbiter;

    localparam int unsigned VRAM_WORDS = 768;
    localparam int unsigned OFFS       = 0;
    localparam int unsigned MAX_DEFER  = 8;

    logic        clock = 1'b0;
    logic        clear;
    logic [15:0] vga_addr;
    logic [15:0] vga_data;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ready;
    logic [15:0] cpu_rdata;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    vram_arbiter #(
        .VRAM_WORDS     (VRAM_WORDS),
        .MEM_ADDR_OFFSET(OFFS),
        .MAX_DEFER      (MAX_DEFER)
    ) dut (
        .clock    (clock),
        .clear    (clear),
        .vga_addr (vga_addr),
        .vga_data (vga_data),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready),
        .cpu_rdata(cpu_rdata),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we   (mem_we),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [15:0] init_word(input int i);
        logic [15:0] a;
        a = 16'(i);
        if (i == 5) return 16'h3A1C;
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    // Synchronous single-port RAM; fills itself on the first clock edge.
    logic [15:0] ram [0:65535];
    bit          ram_ready;
    always @(posedge clock) begin
        if (!ram_ready) begin
            for (int i = 0; i < 65536; i++) ram[i] <= init_word(i);
            ram_ready <= 1'b1;
        end else begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    // Write-enable monitor: total pulses and back-to-back high cycles.
    int   we_count  = 0;
    int   we_double = 0;
    logic we_prev   = 1'b0;
    always @(posedge clock) begin
        we_prev <= mem_we;
        if (mem_we) we_count <= we_count + 1;
        if (mem_we && we_prev) we_double <= we_double + 1;
    end

    // Reference model: what the RAM should hold as seen through the CPU port.
    logic [15:0] model_mem [0:65535];

    function automatic bit model_in_range(input logic [15:0] a);
        return (int'(a) >= int'(OFFS)) && (int'(a) < int'(OFFS + VRAM_WORDS));
    endfunction

    // Issue one CPU op at a negedge; lat counts cycles from request to cpu_ready.
    task automatic cpu_op(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                          input bit chg_vga, input logic [15:0] new_vga,
                          output int lat, output logic [15:0] rdata);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        if (chg_vga) vga_addr = new_vga;
        lat   = -1;
        rdata = 16'hxxxx;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (cpu_ready) begin
                lat   = i;
                rdata = cpu_rdata;
                break;
            end
        end
        cpu_req = 1'b0;
        if (we && model_in_range(addr) && lat > 0) model_mem[addr] = wdata;
    endtask

    task automatic test_reset();
        int w0;
        repeat (3) @(negedge clock);
        n_tests++; if (vga_data !== 16'h0) begin n_fail++; $display("FAIL rst_vga_data: got %h want 0000", vga_data); end
        n_tests++; if (cpu_rdata !== 16'h0) begin n_fail++; $display("FAIL rst_cpu_rdata: got %h want 0000", cpu_rdata); end
        n_tests++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cpu_ready: got %b want 0", cpu_ready); end
        n_tests++; if (mem_addr !== 16'h0) begin n_fail++; $display("FAIL rst_mem_addr: got %h want 0000", mem_addr); end
        n_tests++; if (mem_wdata !== 16'h0) begin n_fail++; $display("FAIL rst_mem_wdata: got %h want 0000", mem_wdata); end
        n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
        clear = 1'b0;
        @(negedge clock);
        n_tests++; if (mem_addr !== 16'h0005) begin n_fail++; $display("FAIL rst_fetch_addr: got %h want 0005", mem_addr); end
        @(negedge clock);
        n_tests++; if (vga_data !== 16'h0) begin n_fail++; $display("FAIL rst_fetch_early: got %h want 0000", vga_data); end
        @(negedge clock);
        n_tests++; if (vga_data !== 16'h3A1C) begin n_fail++; $display("FAIL rst_fetch_data: got %h want 3a1c", vga_data); end
        w0 = we_count;
        repeat (8) @(negedge clock);
        n_tests++; if (mem_addr !== 16'h0005) begin n_fail++; $display("FAIL rst_idle_addr: got %h want 0005", mem_addr); end
        n_tests++; if (we_count != w0) begin n_fail++; $display("FAIL rst_idle_we: got %0d want %0d", we_count, w0); end
        n_tests++; if (vga_data !== 16'h3A1C) begin n_fail++; $display("FAIL rst_idle_data: got %h want 3a1c", vga_data); end
    endtask

    task automatic test_write_read();
        int          w0, lat;
        logic [15:0] rd;
        w0        = we_count;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 16'h0010;
        cpu_wdata = 16'h1234;
        @(negedge clock);
        n_tests++; if (mem_we !== 1'b1 || mem_addr !== 16'h0010 || mem_wdata !== 16'h1234) begin
            n_fail++; $display("FAIL wr_cycle1: got we=%b addr=%h wdata=%h want we=1 addr=0010 wdata=1234", mem_we, mem_addr, mem_wdata); end
        @(negedge clock);
        n_tests++; if (cpu_ready !== 1'b1 || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL wr_cycle2: got ready=%b we=%b want ready=1 we=0", cpu_ready, mem_we); end
        cpu_req = 1'b0;
        model_mem[16'h0010] = 16'h1234;
        @(negedge clock);
        n_tests++; if (we_count - w0 != 1) begin n_fail++; $display("FAIL wr_pulses: got %0d want 1", we_count - w0); end
        cpu_op(1'b0, 16'h0010, 16'h0, 1'b0, 16'h0, lat, rd);
        n_tests++; if (lat != 3) begin n_fail++; $display("FAIL rd_latency: got %0d want 3", lat); end
        n_tests++; if (rd !== 16'h1234) begin n_fail++; $display("FAIL rd_data: got %h want 1234", rd); end
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        int          j;
        logic [15:0] rd;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 16'h0010;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (cpu_ready) break;
        end
        // Keep the request high and move to the next address in the completion cycle.
        cpu_addr = 16'h0011;
        j        = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (cpu_ready) begin
                j  = i;
                rd = cpu_rdata;
                break;
            end
        end
        cpu_req = 1'b0;
        n_tests++; if (j != 4) begin n_fail++; $display("FAIL b2b_latency: got %0d want 4", j); end
        n_tests++; if (rd !== model_mem[16'h0011]) begin n_fail++; $display("FAIL b2b_data: got %h want %h", rd, model_mem[16'h0011]); end
        @(negedge clock);
    endtask

    task automatic test_vga_then_cpu();
        int          lat;
        logic [15:0] rd;
        cpu_op(1'b0, 16'h0010, 16'h0, 1'b1, 16'h0230, lat, rd);
        n_tests++; if (lat != 6) begin n_fail++; $display("FAIL vga_first_latency: got %0d want 6", lat); end
        n_tests++; if (rd !== model_mem[16'h0010]) begin n_fail++; $display("FAIL vga_first_rdata: got %h want %h", rd, model_mem[16'h0010]); end
        n_tests++; if (vga_data !== model_mem[16'h0230]) begin n_fail++; $display("FAIL vga_first_vdata: got %h want %h", vga_data, model_mem[16'h0230]); end
        repeat (2) @(negedge clock);
    endtask

    task automatic test_defer();
        int          lat, t, exp_lat;
        logic [15:0] rd;
        // VGA stays pending at every idle point; each fetch occupies 3 cycles and
        // the CPU wins at the first idle point where it has waited MAX_DEFER cycles.
        t = 0;
        while (t < int'(MAX_DEFER)) t += 3;
        exp_lat  = t + 3;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 16'h0010;
        vga_addr = 16'h0240;
        lat      = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (cpu_ready) begin
                lat = i;
                rd  = cpu_rdata;
                break;
            end
            if (i % 3 == 0) vga_addr = 16'h0240 + 16'(i);
        end
        cpu_req = 1'b0;
        n_tests++; if (lat != exp_lat) begin n_fail++; $display("FAIL defer_latency: got %0d want %0d", lat, exp_lat); end
        n_tests++; if (rd !== model_mem[16'h0010]) begin n_fail++; $display("FAIL defer_rdata: got %h want %h", rd, model_mem[16'h0010]); end
        repeat (8) @(negedge clock);
        n_tests++; if (vga_data !== model_mem[vga_addr]) begin n_fail++; $display("FAIL defer_vga_catchup: got %h want %h", vga_data, model_mem[vga_addr]); end
    endtask

    task automatic test_mid_fetch_change();
        vga_addr = 16'h0210;
        @(negedge clock);
        n_tests++; if (mem_addr !== 16'h0210) begin n_fail++; $display("FAIL mid_addr_a: got %h want 0210", mem_addr); end
        vga_addr = 16'h0220;
        repeat (2) @(negedge clock);
        n_tests++; if (vga_data !== model_mem[16'h0210]) begin n_fail++; $display("FAIL mid_old_word: got %h want %h", vga_data, model_mem[16'h0210]); end
        @(negedge clock);
        n_tests++; if (mem_addr !== 16'h0220) begin n_fail++; $display("FAIL mid_addr_b: got %h want 0220", mem_addr); end
        repeat (2) @(negedge clock);
        n_tests++; if (vga_data !== model_mem[16'h0220]) begin n_fail++; $display("FAIL mid_new_word: got %h want %h", vga_data, model_mem[16'h0220]); end
    endtask

    task automatic test_out_of_range();
        int          w0, lat;
        logic [15:0] rd;
        w0 = we_count;
        cpu_op(1'b1, 16'h0300, 16'hDEAD, 1'b0, 16'h0, lat, rd);
        @(negedge clock);
        n_tests++; if (lat != 2) begin n_fail++; $display("FAIL oor_wr_latency: got %0d want 2", lat); end
        n_tests++; if (we_count != w0) begin n_fail++; $display("FAIL oor_wr_we: got %0d pulses want 0", we_count - w0); end
        cpu_op(1'b0, 16'h0300, 16'h0, 1'b0, 16'h0, lat, rd);
        n_tests++; if (rd !== 16'h0000 || lat != 3) begin n_fail++; $display("FAIL oor_rd: got %h lat %0d want 0000 lat 3", rd, lat); end
        @(negedge clock);
        cpu_op(1'b0, 16'h02FF, 16'h0, 1'b0, 16'h0, lat, rd);
        n_tests++; if (rd !== model_mem[16'h02FF]) begin n_fail++; $display("FAIL top_word_rd: got %h want %h", rd, model_mem[16'h02FF]); end
        @(negedge clock);
    endtask

    task automatic test_clear();
        int          readies;
        int          lat;
        logic [15:0] rd;
        // Abort a read while it sits in its RAM-sampling cycle.
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 16'h0010;
        @(negedge clock);
        #2 clear = 1'b1;
        #1;
        n_tests++; if (vga_data !== 16'h0 || cpu_rdata !== 16'h0 || cpu_ready !== 1'b0) begin
            n_fail++; $display("FAIL clr_rd_outputs: got vga=%h rdata=%h ready=%b want 0000 0000 0", vga_data, cpu_rdata, cpu_ready); end
        n_tests++; if (mem_addr !== 16'h0 || mem_wdata !== 16'h0 || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL clr_rd_mem: got addr=%h wdata=%h we=%b want 0000 0000 0", mem_addr, mem_wdata, mem_we); end
        cpu_req = 1'b0;
        @(negedge clock);
        clear   = 1'b0;
        readies = 0;
        @(negedge clock);
        if (cpu_ready) readies++;
        n_tests++; if (mem_addr !== vga_addr) begin n_fail++; $display("FAIL clr_refetch_addr: got %h want %h", mem_addr, vga_addr); end
        repeat (2) begin @(negedge clock); if (cpu_ready) readies++; end
        n_tests++; if (vga_data !== model_mem[vga_addr]) begin n_fail++; $display("FAIL clr_refetch_data: got %h want %h", vga_data, model_mem[vga_addr]); end
        n_tests++; if (readies != 0) begin n_fail++; $display("FAIL clr_no_ready: got %0d want 0", readies); end
        repeat (2) @(negedge clock);
        // Abort a write while mem_we is high: the write enable must drop at once.
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 16'h0020;
        cpu_wdata = 16'hBEEF;
        @(negedge clock);
        #2 clear = 1'b1;
        #1;
        n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL clr_we_async: got %b want 0", mem_we); end
        cpu_req = 1'b0;
        @(negedge clock);
        clear = 1'b0;
        repeat (5) @(negedge clock);
        cpu_op(1'b0, 16'h0020, 16'h0, 1'b0, 16'h0, lat, rd);
        n_tests++; if (rd !== model_mem[16'h0020]) begin n_fail++; $display("FAIL clr_wr_dropped: got %h want %h", rd, model_mem[16'h0020]); end
        @(negedge clock);
    endtask

    task automatic test_random();
        int          lat, exp_lat, w0, exp_we;
        logic [15:0] rd, addr, wdata, nv, exp_rd;
        logic        we;
        bit          chg;
        for (int n = 0; n < 40; n++) begin
            we = 1'($urandom_range(0, 1));
            if (we) begin
                addr = ($urandom_range(0, 3) == 0) ? 16'(16'h0300 + $urandom_range(0, 16'hFCFF))
                                                   : 16'($urandom_range(0, 16'h01FF));
            end else begin
                addr = 16'($urandom);
            end
            wdata  = 16'($urandom);
            chg    = 1'($urandom_range(0, 1));
            nv     = 16'(16'h0200 + $urandom_range(0, 255));
            if (nv == vga_addr) nv = nv ^ 16'h0001;
            exp_lat = (we ? 2 : 3) + (chg ? 3 : 0);
            exp_we  = (we && model_in_range(addr)) ? 1 : 0;
            exp_rd  = model_in_range(addr) ? model_mem[addr] : 16'h0000;
            w0      = we_count;
            cpu_op(we, addr, wdata, chg, nv, lat, rd);
            repeat (6) @(negedge clock);
            n_tests++; if (lat != exp_lat) begin n_fail++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", n, lat, exp_lat); end
            if (we) begin
                n_tests++; if (we_count - w0 != exp_we) begin n_fail++; $display("FAIL rnd_we[%0d]: got %0d want %0d", n, we_count - w0, exp_we); end
            end else begin
                n_tests++; if (rd !== exp_rd) begin n_fail++; $display("FAIL rnd_rdata[%0d] @%h: got %h want %h", n, addr, rd, exp_rd); end
            end
            n_tests++; if (vga_data !== model_mem[vga_addr]) begin n_fail++; $display("FAIL rnd_vga[%0d] @%h: got %h want %h", n, vga_addr, vga_data, model_mem[vga_addr]); end
        end
    endtask

    initial begin
        clear     = 1'b1;
        vga_addr  = 16'h0005;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 16'h0;
        cpu_wdata = 16'h0;
        for (int i = 0; i < 65536; i++) model_mem[i] = init_word(i);
        test_reset();
        test_write_read();
        test_back_to_back();
        test_vga_then_cpu();
        test_defer();
        test_mid_fetch_change();
        test_out_of_range();
        test_clear();
        test_random();
        n_tests++; if (we_double != 0) begin n_fail++; $display("FAIL we_single_cycle: got %0d wide pulses want 0", we_double); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
